// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    localparam logic [3:0] DEF_PATTERN = 4'b1010;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;

    function automatic bit pat_len_ok(input int len);
        return (len >= PAT_LEN_MIN) && (len <= PAT_LEN_MAX);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with a sticky saturation flag; clear beats increment.
module seq_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == (CNT_MAX - CNT_W'(1))) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector (overlapping / non-overlapping) with match counter.
// Define SEQDET_PROG_EN to add a run-time loadable pattern (pat_load / pat_in).
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ip,
    input  logic               ip_valid,
    input  logic               overlap,
    input  logic               clr_cnt,
`ifdef SEQDET_PROG_EN
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
`endif
    output logic               op,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int                FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN out of range");
    end

    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    state_t             r_state;
    logic               r_op;

    logic [PAT_LEN-2:0] w_hist_next;
    logic [FILL_W-1:0]  w_fill_next;
    state_t             w_state_next;
    logic [PAT_LEN-1:0] w_window;
    logic [PAT_LEN-1:0] w_pattern;
    logic               w_load;
    logic               w_match;

`ifdef SEQDET_PROG_EN
    logic [PAT_LEN-1:0] r_pattern;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pattern <= PATTERN;
        end else if (pat_load) begin
            r_pattern <= pat_in;
        end
    end

    assign w_pattern = r_pattern;
    assign w_load    = pat_load;
`else
    assign w_pattern = PATTERN;
    assign w_load    = 1'b0;
`endif

    // The current bit completes the window; hist holds the older PAT_LEN-1 bits.
    assign w_window = {r_hist, ip};
    assign w_match  = !w_load && (r_state == S_ARMED) && ip_valid && (w_window == w_pattern);

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_hist_next  = r_hist;
        w_fill_next  = r_fill;
        w_state_next = r_state;
        if (w_load) begin
            w_hist_next  = '0;
            w_fill_next  = '0;
            w_state_next = S_FILL;
        end else if (ip_valid) begin
            if (w_match && !overlap) begin
                w_hist_next  = '0;
                w_fill_next  = '0;
                w_state_next = S_FILL;
            end else begin
                w_hist_next = w_window[PAT_LEN-2:0];
                if (r_state == S_FILL) begin
                    w_fill_next = r_fill + FILL_W'(1);
                    if (r_fill == (FILL_MAX - FILL_W'(1))) begin
                        w_state_next = S_ARMED;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= S_FILL;
            r_op    <= 1'b0;
        end else begin
            r_hist  <= w_hist_next;
            r_fill  <= w_fill_next;
            r_state <= w_state_next;
            r_op    <= w_match;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_match),
        .i_clr (clr_cnt),
        .o_cnt (match_cnt),
        .o_sat (cnt_sat)
    );

    assign op = r_op;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_seq_detector_param;

    localparam int         PAT_LEN = 4;
    localparam logic [3:0] PATTERN = 4'b1010;
    localparam int         MAX_A   = 255;
    localparam int         MAX_B   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ip, ip_valid, overlap, clr_cnt;
`ifdef SEQDET_PROG_EN
    logic       pat_load;
    logic [3:0] pat_in;
`endif
    logic       op_a, sat_a, op_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the valid bits received since the last flush, newest at the back.
    bit         q[$];
    logic [3:0] m_pat;
    bit         e_op;
    int         e_cnt_a, e_cnt_b;
    bit         e_sat_a, e_sat_b;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(8)) dut_a (
        .clk       (clk),
        .reset     (rst_n),
        .ip        (ip),
        .ip_valid  (ip_valid),
        .overlap   (overlap),
        .clr_cnt   (clr_cnt),
`ifdef SEQDET_PROG_EN
        .pat_load  (pat_load),
        .pat_in    (pat_in),
`endif
        .op        (op_a),
        .match_cnt (cnt_a),
        .cnt_sat   (sat_a)
    );

    seq_detector_param #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(2)) dut_b (
        .clk       (clk),
        .reset     (rst_n),
        .ip        (ip),
        .ip_valid  (ip_valid),
        .overlap   (overlap),
        .clr_cnt   (clr_cnt),
`ifdef SEQDET_PROG_EN
        .pat_load  (pat_load),
        .pat_in    (pat_in),
`endif
        .op        (op_b),
        .match_cnt (cnt_b),
        .cnt_sat   (sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_op_a"},  {31'd0, op_a},  {31'd0, e_op});
        chk({tag, "_op_b"},  {31'd0, op_b},  {31'd0, e_op});
        chk({tag, "_cnt_a"}, {24'd0, cnt_a}, e_cnt_a);
        chk({tag, "_sat_a"}, {31'd0, sat_a}, {31'd0, e_sat_a});
        chk({tag, "_cnt_b"}, {30'd0, cnt_b}, e_cnt_b);
        chk({tag, "_sat_b"}, {31'd0, sat_b}, {31'd0, e_sat_b});
    endtask

    task automatic model_reset();
        q.delete();
        m_pat   = PATTERN;
        e_op    = 1'b0;
        e_cnt_a = 0;
        e_cnt_b = 0;
        e_sat_a = 1'b0;
        e_sat_b = 1'b0;
    endtask

    task automatic idle_inputs();
        ip       = 1'b0;
        ip_valid = 1'b0;
        overlap  = 1'b0;
        clr_cnt  = 1'b0;
`ifdef SEQDET_PROG_EN
        pat_load = 1'b0;
        pat_in   = '0;
`endif
    endtask

    // One clock: drive at negedge, predict, check #1 after the posedge.
    task automatic step(input string tag, input bit b, input bit v, input bit ov, input bit clr,
                        input bit ld = 1'b0, input logic [3:0] pin = 4'd0);
        bit m;
        m = 1'b0;
        @(negedge clk);
        ip       = b;
        ip_valid = v;
        overlap  = ov;
        clr_cnt  = clr;
`ifdef SEQDET_PROG_EN
        pat_load = ld;
        pat_in   = pin;
`endif
        if (ld) begin
            m_pat = pin;
            q.delete();
        end else if (v) begin
            q.push_back(b);
            if (q.size() > PAT_LEN) void'(q.pop_front());
            if (q.size() == PAT_LEN) begin
                m = 1'b1;
                for (int i = 0; i < PAT_LEN; i++)
                    if (q[i] != m_pat[PAT_LEN-1-i]) m = 1'b0;
            end
            if (m && !ov) q.delete();
        end
        e_op = m;
        if (clr) begin
            e_cnt_a = 0; e_sat_a = 1'b0;
            e_cnt_b = 0; e_sat_b = 1'b0;
        end else if (m) begin
            if (e_cnt_a < MAX_A) e_cnt_a++;
            if (e_cnt_a == MAX_A) e_sat_a = 1'b1;
            if (e_cnt_b < MAX_B) e_cnt_b++;
            if (e_cnt_b == MAX_B) e_sat_b = 1'b1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic feed(input string tag, input logic [15:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(tag, bits[i], 1'b1, ov, 1'b0);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic reset_mid(input string tag);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset clears a live pulse; a half pattern is discarded by reset.
        feed("t1_pre", 16'b1010, 4, 1'b1);
        chk("t1_pulse", {31'd0, op_a}, 32'd1);
        reset_mid("t1_async");
        feed("t1_half", 16'b10, 2, 1'b1);
        reset_mid("t1_half_rst");
        feed("t1_after", 16'b10, 2, 1'b1);
        chk("t1_nomatch_cnt", {24'd0, cnt_a}, 32'd0);

        // Overlapping: pulses after bits 4 and 6.
        reset_mid("t2_rst");
        feed("t2", 16'b101010, 6, 1'b1);
        chk("t2_cnt", {24'd0, cnt_a}, 32'd2);

        // Non-overlapping: a single pulse.
        reset_mid("t3_rst");
        feed("t3", 16'b101010, 6, 1'b0);
        chk("t3_cnt", {24'd0, cnt_a}, 32'd1);

        // Gaps between valid bits.
        reset_mid("t4_rst");
        for (int i = 3; i >= 0; i--) begin
            step("t4_bit", PATTERN[i], 1'b1, 1'b1, 1'b0);
            step("t4_gap", 1'($urandom), 1'b0, 1'b1, 1'b0);
            step("t4_gap", 1'($urandom), 1'b0, 1'b1, 1'b0);
        end
        chk("t4_cnt", {24'd0, cnt_a}, 32'd1);

        // Saturation of the 2-bit counter, then clear coincident with a match.
        reset_mid("t5_rst");
        feed("t5", 16'hAAAA, 16, 1'b1);
        chk("t5_cnt_a", {24'd0, cnt_a}, 32'd7);
        chk("t5_cnt_b", {30'd0, cnt_b}, 32'd3);
        chk("t5_sat_b", {31'd0, sat_b}, 32'd1);
        step("t5_clr", 1'b1, 1'b1, 1'b1, 1'b0);
        step("t5_clr", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5_clr_op", {31'd0, op_b}, 32'd1);
        chk("t5_clr_cnt", {30'd0, cnt_b}, 32'd0);

        // Random traffic against the model.
        reset_mid("rnd_rst");
        for (int i = 0; i < 800; i++) begin
            if (($urandom % 200) == 0) reset_mid("rnd_midrst");
            step("rnd", 1'($urandom), ($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0);
        end

`ifdef SEQDET_PROG_EN
        // Load 0110 mid-stream: history flushed, old pattern retired.
        reset_mid("t6_rst");
        feed("t6_pre", 16'b011, 3, 1'b1);
        step("t6_load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0110);
        chk("t6_load_op", {31'd0, op_a}, 32'd0);
        feed("t6_new", 16'b0110, 4, 1'b1);
        chk("t6_new_op", {31'd0, op_a}, 32'd1);
        feed("t6_old", 16'b1010, 4, 1'b1);
        chk("t6_cnt", {24'd0, cnt_a}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
